// File: rtl/reception_pkg.sv
// reception_pkg: codes shared by the visitor queue and its FIFO.
//   Query codes   : what a visitor asks the desk for.
//   Message codes : what the desk replies with.
//   state_t       : desk handshake states of visitor_queue.
//   is_grant()    : true when a desk reply assigns a room.
package reception_pkg;

    localparam logic [1:0] QRY_A    = 2'b00;
    localparam logic [1:0] QRY_ANY0 = 2'b01;
    localparam logic [1:0] QRY_ANY1 = 2'b10;
    localparam logic [1:0] QRY_B    = 2'b11;

    localparam logic [1:0] MSG_NONE = 2'b00;
    localparam logic [1:0] MSG_A    = 2'b01;
    localparam logic [1:0] MSG_B    = 2'b10;
    localparam logic [1:0] MSG_BUSY = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        WAIT    = 3'd3,
        EVAL    = 3'd4,
        BACKOFF = 3'd5
    } state_t;

    function automatic logic is_grant(input logic [1:0] msg);
        return (msg == MSG_A) || (msg == MSG_B);
    endfunction

endpackage

// File: rtl/vq_fifo.sv
// vq_fifo: small first-word-fall-through FIFO holding waiting visitors.
//   clk, rst      : clock, asynchronous active-high reset (empties the FIFO)
//   push, din     : write request and data; accepted when not full, or when
//                   a pop happens in the same cycle (pop frees the slot first)
//   pop           : remove the head entry (ignored when empty)
//   dout          : current head entry (combinational read of the head slot)
//   full, empty   : status flags
//   count         : number of stored entries, width clog2(DEPTH)+1
// DEPTH must be a power of two so the pointers wrap naturally.
module vq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Storage carries no reset: contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/visitor_queue.sv
// visitor_queue: queues arriving visitors and negotiates a room for the head
// visitor with a reception desk through a start/message handshake.
//   clk, rst        : clock, asynchronous active-high reset
//   arrive          : one-cycle strobe, enqueue arrive_query
//   arrive_query[2] : visitor request code
//   message[2]      : desk reply (01 room A, 10 room B, 11 busy, 00 none)
//   query[2]        : head visitor's request (00 when the queue is empty)
//   start           : one-cycle desk strobe, high only in STROBE
//   assigned_valid  : pulse when the head visitor is given a room
//   assigned_room[2]: room code valid with assigned_valid
//   drop            : pulse the cycle after an arrival lost to a full queue
//   q_full, q_empty : queue status
// Optional feature, macro VISITOR_QUEUE_STATS_EN: adds 8-bit saturating
// outputs served_count (grants) and busy_count (EVAL->BACKOFF transitions).
// RESP_WAIT and RETRY_WAIT must be at least 1.
module visitor_queue
    import reception_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int RESP_WAIT  = 2,
    parameter int RETRY_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arrive,
    input  logic [1:0] arrive_query,
    input  logic [1:0] message,
    output logic [1:0] query,
    output logic       start,
    output logic       assigned_valid,
    output logic [1:0] assigned_room,
    output logic       drop,
    output logic       q_full,
    output logic       q_empty
`ifdef VISITOR_QUEUE_STATS_EN
    ,
    output logic [7:0] served_count,
    output logic [7:0] busy_count
`endif
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int MAXW  = (RESP_WAIT > RETRY_WAIT) ? RESP_WAIT : RETRY_WAIT;
    localparam int TW    = $clog2(MAXW + 1);

    state_t          state_reg;
    state_t          state_next;
    logic [TW-1:0]   timer_reg;
    logic [TW-1:0]   timer_next;
    logic            drop_reg;

    logic [1:0]      head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            grant;

    vq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (arrive),
        .pop   (pop),
        .din   (arrive_query),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A grant in EVAL frees the head slot in the same cycle, so a coincident
    // arrival on a full queue is stored rather than dropped.
    assign grant          = (state_reg == EVAL) && is_grant(message);
    assign pop            = grant;
    assign assigned_valid = grant;
    assign assigned_room  = grant ? message : MSG_NONE;
    assign start          = (state_reg == STROBE);
    assign query          = fifo_empty ? QRY_A : head;
    assign q_full         = fifo_full;
    assign q_empty        = fifo_empty;
    assign drop           = drop_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            drop_reg  <= arrive && (fifo_count == CW'(DEPTH)) && !pop;
        end
    end

    // Timer counts up inside WAIT/BACKOFF and is cleared on every exit so
    // each timed state starts from zero.
    always_comb begin
        state_next = state_reg;
        timer_next = '0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = STROBE;
            end
            STROBE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (timer_reg == TW'(RESP_WAIT - 1)) begin
                    state_next = EVAL;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            EVAL: begin
                state_next = is_grant(message) ? IDLE : BACKOFF;
            end
            BACKOFF: begin
                if (timer_reg == TW'(RETRY_WAIT - 1)) begin
                    state_next = SETUP;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef VISITOR_QUEUE_STATS_EN
    logic [7:0] served_reg;
    logic [7:0] busy_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            served_reg <= 8'd0;
            busy_reg   <= 8'd0;
        end else begin
            if (grant && (served_reg != 8'hFF)) begin
                served_reg <= served_reg + 8'd1;
            end
            if ((state_reg == EVAL) && !is_grant(message) && (busy_reg != 8'hFF)) begin
                busy_reg <= busy_reg + 8'd1;
            end
        end
    end

    assign served_count = served_reg;
    assign busy_count   = busy_reg;
`endif

endmodule

// File: tb/tb_visitor_queue.sv
// tb_visitor_queue: directed stimulus for visitor_queue with a scoreboard.
// Stimulus pushes the expected {query, room} of each grant; a monitor on the
// falling clock edge pops and compares whenever assigned_valid is seen.
// Define VISITOR_QUEUE_STATS_EN to also exercise the statistics outputs.
module tb_visitor_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       arrive;
    logic [1:0] arrive_query;
    logic [1:0] message;
    logic [1:0] query;
    logic       start;
    logic       assigned_valid;
    logic [1:0] assigned_room;
    logic       drop;
    logic       q_full;
    logic       q_empty;
`ifdef VISITOR_QUEUE_STATS_EN
    logic [7:0] served_count;
    logic [7:0] busy_count;
`endif

    visitor_queue #(
        .DEPTH      (4),
        .RESP_WAIT  (2),
        .RETRY_WAIT (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .arrive         (arrive),
        .arrive_query   (arrive_query),
        .message        (message),
        .query          (query),
        .start          (start),
        .assigned_valid (assigned_valid),
        .assigned_room  (assigned_room),
        .drop           (drop),
        .q_full         (q_full),
        .q_empty        (q_empty)
`ifdef VISITOR_QUEUE_STATS_EN
        ,
        .served_count   (served_count),
        .busy_count     (busy_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int drop_seen = 0;
    logic [3:0] sb [$];   // {expected query, expected room}

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!(q_empty && sb.size() == 0) && k < budget) begin
            step();
            k++;
        end
        check("wait_idle_timeout", 8'(k < budget), 8'd1);
        repeat (2) step();
    endtask

    task automatic enqueue(input logic [1:0] q);
        arrive       = 1'b1;
        arrive_query = q;
        step();
        arrive       = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (drop) drop_seen++;
            if (assigned_valid) begin
                logic [3:0] e;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_grant: query %0h room %0h with empty scoreboard (t=%0t)",
                             query, assigned_room, $time);
                end else begin
                    e = sb.pop_front();
                    $display("grant: query %0h room %0h (expected query %0h room %0h)",
                             query, assigned_room, e[3:2], e[1:0]);
                    check("grant_query", 8'(query), 8'(e[3:2]));
                    check("grant_room", 8'(assigned_room), 8'(e[1:0]));
                end
            end
        end
    end

    initial begin
        logic [1:0] q3 [5];
        logic [1:0] q4 [4];
        int starts;
        int t_start [3];
        int k;
        int drops_before;

        q3[0] = 2'b00; q3[1] = 2'b01; q3[2] = 2'b10; q3[3] = 2'b11; q3[4] = 2'b01;
        q4[0] = 2'b11; q4[1] = 2'b10; q4[2] = 2'b01; q4[3] = 2'b00;

        rst = 1'b1; arrive = 1'b0; arrive_query = 2'b00; message = 2'b00;
        #1;
        // Reset state (asynchronous: visible before any clock edge)
        check("rst_q_empty", 8'(q_empty), 8'd1);
        check("rst_q_full", 8'(q_full), 8'd0);
        check("rst_start", 8'(start), 8'd0);
        check("rst_query", 8'(query), 8'd0);
        check("rst_assigned_valid", 8'(assigned_valid), 8'd0);
        check("rst_drop", 8'(drop), 8'd0);
        repeat (2) step();
        rst = 1'b0;
        step();

        // Single visitor, immediate grant: start 2 cycles after arrive, grant at 5
        message = 2'b01;
        sb.push_back({2'b01, 2'b01});
        enqueue(2'b01);
        check("t1_nonempty", 8'(q_empty), 8'd0);
        check("t1_setup_start", 8'(start), 8'd0);
        step();
        check("t1_setup_query", 8'(query), 8'd1);
        check("t1_setup_start2", 8'(start), 8'd0);
        step();
        check("t1_strobe_start", 8'(start), 8'd1);
        check("t1_strobe_query", 8'(query), 8'd1);
        step();
        check("t1_wait_start", 8'(start), 8'd0);
        repeat (2) step();
        check("t1_eval_valid", 8'(assigned_valid), 8'd1);
        check("t1_eval_room", 8'(assigned_room), 8'd1);
        step();
        check("t1_after_empty", 8'(q_empty), 8'd1);
        check("t1_after_valid", 8'(assigned_valid), 8'd0);
        wait_idle(20);

        // Busy desk: start repeats every 13 cycles, head retained
        message = 2'b11;
        enqueue(2'b10);
        starts = 0;
        for (int i = 0; i < 45; i++) begin
            step();
            if (start && starts < 3) begin
                t_start[starts] = i;
                starts++;
            end
        end
        check("t2_start_count", 8'(starts), 8'd3);
        check("t2_period_a", 8'(t_start[1] - t_start[0]), 8'd13);
        check("t2_period_b", 8'(t_start[2] - t_start[1]), 8'd13);
        check("t2_head_query", 8'(query), 8'd2);
        check("t2_not_empty", 8'(q_empty), 8'd0);
        sb.push_back({2'b10, 2'b10});
        message = 2'b10;
        wait_idle(40);

        // Five back-to-back arrivals into a 4-deep queue: fifth dropped
        message = 2'b10;
        drops_before = drop_seen;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb.push_back({q3[i], 2'b10});
            arrive = 1'b1;
            arrive_query = q3[i];
            step();
            if (i == 3) check("t3_full", 8'(q_full), 8'd1);
            if (i == 4) check("t3_drop_pulse", 8'(drop), 8'd1);
        end
        arrive = 1'b0;
        step();
        check("t3_drop_one_cycle", 8'(drop), 8'd0);
        wait_idle(80);
        check("t3_drop_total", 8'(drop_seen - drops_before), 8'd1);

        // Full queue, arrival coincident with a grant pop: accepted, no drop
        message = 2'b00;
        for (int i = 0; i < 4; i++) begin
            sb.push_back({q4[i], 2'b01});
            enqueue(q4[i]);
        end
        check("t4_full", 8'(q_full), 8'd1);
        k = 0;
        while (!start && k < 40) begin
            step();
            k++;
        end
        check("t4_start_seen", 8'(start), 8'd1);
        message = 2'b01;
        repeat (3) step();
        check("t4_eval_grant", 8'(assigned_valid), 8'd1);
        sb.push_back({2'b10, 2'b01});
        arrive = 1'b1;
        arrive_query = 2'b10;
        step();
        arrive = 1'b0;
        check("t4_no_drop", 8'(drop), 8'd0);
        check("t4_still_full", 8'(q_full), 8'd1);
        wait_idle(100);

        // Reset in the middle of STROBE
        message = 2'b11;
        enqueue(2'b01);
        k = 0;
        while (!start && k < 10) begin
            step();
            k++;
        end
        check("t5_strobe_reached", 8'(start), 8'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_start", 8'(start), 8'd0);
        check("t5_rst_empty", 8'(q_empty), 8'd1);
        check("t5_rst_query", 8'(query), 8'd0);
        check("t5_rst_valid", 8'(assigned_valid), 8'd0);
        repeat (2) step();
        rst = 1'b0;
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (start) starts++;
        end
        check("t5_no_start_after_rst", 8'(starts), 8'd0);
        message = 2'b01;
        sb.push_back({2'b11, 2'b01});
        enqueue(2'b11);
        wait_idle(20);

`ifdef VISITOR_QUEUE_STATS_EN
        // Three busy replies then a grant
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("t6_served_rst", served_count, 8'd0);
        check("t6_busy_rst", busy_count, 8'd0);
        message = 2'b11;
        enqueue(2'b00);
        starts = 0;
        k = 0;
        while (starts < 4 && k < 80) begin
            step();
            k++;
            if (start) begin
                starts++;
                if (starts == 4) begin
                    sb.push_back({2'b00, 2'b01});
                    message = 2'b01;
                end
            end
        end
        check("t6_four_starts", 8'(starts), 8'd4);
        wait_idle(20);
        check("t6_busy_count", busy_count, 8'd3);
        check("t6_served_count", served_count, 8'd1);
`endif

        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/visitor_queue.md
VISITOR_QUEUE -- requirements
Module: visitor_queue

Interface
REQ-001 Parameter DEPTH, default 4: visitor FIFO entries, power of two, 2..16.
REQ-002 Parameter RESP_WAIT, default 2: cycles after start falls before message is sampled.
REQ-003 Parameter RETRY_WAIT, default 8: backoff cycles after a busy reply.
REQ-004 clk  in  1  sole clock; all state on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 arrive  in  1  one-cycle strobe; enqueue one visitor.
REQ-007 arrive_query  in  2  visitor request code, sampled with arrive.
REQ-008 message  in  2  desk reply: 01 room A, 10 room B, 11 busy, 00 none.
REQ-009 query  out  2  head visitor's request, presented to the desk.
REQ-010 start  out  1  desk strobe; the desk acts on its falling edge.
REQ-011 assigned_valid  out  1  one-cycle pulse when the head visitor is served.
REQ-012 assigned_room  out  2  room code (01/10), valid with assigned_valid.
REQ-013 drop  out  1  one-cycle pulse when an arrival is lost because the FIFO is full.
REQ-014 q_full, q_empty  out  1 each  FIFO status flags.

Function
REQ-015 Arrivals enqueue in order; on arrive with the FIFO full: no write, drop=1 next cycle.
REQ-016 Simultaneous arrive and pop on a full FIFO: pop first, write accepted, no drop.
REQ-017 FSM states: IDLE, SETUP, STROBE, WAIT, EVAL, BACKOFF.
REQ-018 IDLE -> SETUP when !q_empty; query driven from the FIFO head; start=0.
REQ-019 SETUP: one cycle, query held stable -> STROBE.
REQ-020 STROBE: start=1 for exactly one cycle -> WAIT; query held stable throughout.
REQ-021 WAIT: RESP_WAIT cycles with start=0 -> EVAL.
REQ-022 EVAL, message 01 or 10: pop head; assigned_valid=1; assigned_room=message -> IDLE.
REQ-023 EVAL, message 11 or 00: no pop -> BACKOFF.
REQ-024 BACKOFF: RETRY_WAIT cycles -> SETUP; the same head visitor is retried indefinitely.
REQ-025 Latency, idle non-empty FIFO to assigned_valid: 3+RESP_WAIT cycles.
REQ-026 Counters and pointers wrap modulo their width; the FIFO count width is clog2(DEPTH)+1.
REQ-027 query=00 when q_empty; start is never high outside STROBE.

Reset
REQ-028 rst immediately forces: FIFO empty (q_empty=1, q_full=0), state IDLE, start=0, query=00.
REQ-029 rst also immediately clears assigned_valid=0, assigned_room=00, drop=0, and all counters.
REQ-030 Reset during STROBE drops start without completing the handshake; the pending visitor is lost.

Configuration
REQ-031 With macro VISITOR_QUEUE_STATS_EN defined, the block adds two 8-bit outputs, served_count and busy_count.
REQ-032 served_count increments on each assigned_valid; busy_count increments on each EVAL->BACKOFF; both saturate at 255; reset value 0.
REQ-033 Without VISITOR_QUEUE_STATS_EN, neither port nor counter exists and all other behaviour is identical.

Structure
REQ-034 Shared package reception_pkg holds the query codes (QRY_A=00, QRY_ANY0=01, QRY_ANY1=10, QRY_B=11).
REQ-035 reception_pkg also holds the message codes (MSG_NONE=00, MSG_A=01, MSG_B=10, MSG_BUSY=11) and the FSM state typedef.
REQ-036 The FIFO is a sub-module vq_fifo (parameter DEPTH; ports push, pop, din, dout, full, empty, count).

Verification
REQ-037 Defaults; arrive with query 01; message tied 01 -> start pulse 2 cycles after arrive; assigned_valid with room 01 at cycle 5+; q_empty=1.
REQ-038 message tied 11 -> start repeats every 3+RESP_WAIT+RETRY_WAIT=13 cycles; no assigned_valid; head retained.
REQ-039 5 arrivals back-to-back, DEPTH=4, message 10 -> exactly one drop pulse on the 5th; 4 assignments in arrival order.
REQ-040 Full FIFO; arrive coincident with EVAL pop (message 01) -> no drop; count stays 4.
REQ-041 rst asserted mid-STROBE -> start=0 in the same cycle; q_empty=1; after release, no start until a new arrive.
REQ-042 VISITOR_QUEUE_STATS_EN defined; 3 busy replies then 1 grant -> busy_count=3, served_count=1.
